// File: rtl/hd44780_queued_sender.sv
// Buffered HD44780 write engine: queues (rs, byte) writes and drains them as 4- or
// 8-bit E-strobed bus cycles, then waits a per-command settle time after each byte.
module hd44780_queued_sender #(
  parameter int BUS_WIDTH  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int T_AS       = 1,
  parameter int T_PWEH     = 6,
  parameter int T_AH       = 1,
  parameter int T_E_PAD    = 7,
  parameter int T_CMD      = 636,
  parameter int T_CLR      = 19200,
  parameter int CNT_BITS   = 16
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  input  logic                        STB_I,
  input  logic                        i_rs,
  input  logic [7:0]                  i_lcd_data,
  output logic                        ACK_O,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_ovf,
  output logic                        o_rs,
  output logic                        o_e,
  output logic [BUS_WIDTH-1:0]        o_lcd_data,
  output logic [2:0]                  dbg_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    PAD   = 3'd4,
    WAIT  = 3'd5
  } state_t;

  state_t              state;
  logic [8:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                stb_q;
  logic                half;
  logic [8:0]          cur;
  logic [8:0]          head;
  logic [CNT_BITS-1:0] timer;
  logic                push_req;
  logic                push_ok;
  logic                pop_ok;
  logic                full;
  logic                more_nyb;
  logic                is_clr;

  // Valid/ready: a push is offered on the 0->1 edge of STB_I and is ready only when
  // the pre-edge level is below FIFO_DEPTH; ACK_O reports acceptance one cycle later.
  assign head      = mem[rd_ptr];
  assign push_req  = STB_I && !stb_q;
  assign full      = (o_level == LW'(FIFO_DEPTH));
  assign push_ok   = push_req && !full;
  assign pop_ok    = (state == IDLE) && (o_level != '0);
  assign more_nyb  = (BUS_WIDTH == 4) && !half;
  assign is_clr    = !cur[8] && (cur[7:1] == 7'd0) && (cur[7:0] != 8'd0);
  assign busy      = (o_level != '0) || (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge CLK_I) begin
    if (push_ok) mem[wr_ptr] <= {i_rs, i_lcd_data};
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      stb_q      <= 1'b0;
      half       <= 1'b0;
      cur        <= '0;
      timer      <= '0;
      ACK_O      <= 1'b0;
      o_ovf      <= 1'b0;
      o_rs       <= 1'b0;
      o_e        <= 1'b0;
      o_lcd_data <= '0;
    end else begin
      stb_q <= STB_I;
      ACK_O <= push_ok;
      if (push_req && full) o_ovf <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   o_level <= o_level + LW'(1);
        2'b01:   o_level <= o_level - LW'(1);
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (pop_ok) begin
            cur        <= head;
            half       <= 1'b0;
            o_rs       <= head[8];
            o_lcd_data <= head[7 -: BUS_WIDTH];
            timer      <= CNT_BITS'(T_AS - 1);
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (timer != '0) timer <= timer - CNT_BITS'(1);
          else begin
            o_e   <= 1'b1;
            timer <= CNT_BITS'(T_PWEH - 1);
            state <= PULSE;
          end
        end
        PULSE: begin
          if (timer != '0) timer <= timer - CNT_BITS'(1);
          else begin
            o_e   <= 1'b0;
            timer <= CNT_BITS'(T_AH - 1);
            state <= HOLD;
          end
        end
        HOLD, PAD: begin
          // With T_E_PAD == 0 the nybble ends straight out of HOLD.
          if (timer != '0) timer <= timer - CNT_BITS'(1);
          else if (state == HOLD && T_E_PAD > 0) begin
            timer <= CNT_BITS'(T_E_PAD - 1);
            state <= PAD;
          end else if (more_nyb) begin
            half       <= 1'b1;
            o_lcd_data <= cur[BUS_WIDTH-1:0];
            timer      <= CNT_BITS'(T_AS - 1);
            state      <= SETUP;
          end else begin
            timer <= is_clr ? CNT_BITS'(T_CLR - 1) : CNT_BITS'(T_CMD - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (timer != '0) timer <= timer - CNT_BITS'(1);
          else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hd44780_queued_sender.sv
// Directed bench for hd44780_queued_sender: a 4-bit instance for timing/queueing
// and an 8-bit instance for the single-pulse bus mode.
module tb_hd44780_queued_sender;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0, rs_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ack, busy, ovf, lrs, le;
  logic [4:0] level;
  logic [3:0] ldata;
  logic [2:0] st;

  logic       stb8 = 1'b0;
  logic       ack8, busy8, ovf8, lrs8, le8;
  logic [4:0] level8;
  logic [7:0] ldata8;
  logic [2:0] st8;

  int n_vec = 0, n_err = 0, cyc = 0;
  int ack_cnt = 0, ack_cyc = 0, n_pulse = 0, last_rise = 0, last_fall = 0, max_level = 0;
  int wcnt = 0, base_pulse = 0, base_ack = 0, n_to = 0;
  int rise_q[$];
  int wait_q[$];
  logic [8:0] exp_q[$];
  logic       e_prev = 1'b0, have_hi = 1'b0, hi_rs = 1'b0;
  logic [3:0] hi_nyb = 4'h0;

  hd44780_queued_sender u_dut4 (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(stb), .i_rs(rs_in), .i_lcd_data(data_in),
    .ACK_O(ack), .busy(busy), .o_level(level), .o_ovf(ovf), .o_rs(lrs), .o_e(le),
    .o_lcd_data(ldata), .dbg_state(st)
  );

  hd44780_queued_sender #(.BUS_WIDTH(8)) u_dut8 (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(stb8), .i_rs(rs_in), .i_lcd_data(data_in),
    .ACK_O(ack8), .busy(busy8), .o_level(level8), .o_ovf(ovf8), .o_rs(lrs8), .o_e(le8),
    .o_lcd_data(ldata8), .dbg_state(st8)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: rebuild bytes from E pulses of the 4-bit instance
  always @(negedge clk) begin
    if (!rst_n) begin
      have_hi = 1'b0;
      e_prev  = 1'b0;
      wcnt    = 0;
    end else begin
      if (ack) begin ack_cnt++; ack_cyc = cyc; end
      if (int'(level) > max_level) max_level = int'(level);
      if (le && !e_prev) begin
        n_pulse++;
        last_rise = cyc;
        rise_q.push_back(cyc);
        if (!have_hi) begin
          hi_nyb  = ldata;
          hi_rs   = lrs;
          have_hi = 1'b1;
        end else begin
          have_hi = 1'b0;
          check("rs_stable", 32'(lrs), 32'(hi_rs));
          if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 32'd1);
          else check("drain_byte", 32'({lrs, hi_nyb, ldata}), 32'(exp_q.pop_front()));
        end
      end
      if (!le && e_prev) begin
        last_fall = cyc;
        check("e_width", 32'(cyc - last_rise), 32'd6);
      end
      e_prev = le;
      if (st == 3'd5) wcnt++;
      else if (wcnt != 0) begin wait_q.push_back(wcnt); wcnt = 0; end
    end
  end

  // drivers
  task automatic push(input logic r, input logic [7:0] d, input int hold);
    @(negedge clk);
    rs_in = r; data_in = d; stb = 1'b1;
    repeat (hold) @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    #1;
    check(tag, 32'(busy), 32'd0);
  endtask

  int t_idle, cnt_sh, cnt_e8, rises8;
  logic e8_prev;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    check("rst_e",     32'(le),    32'd0);
    check("rst_outs",  32'({ack, lrs, ldata}), 32'd0);

    // 1: single rs=1 0x6D byte, nybble timing and settle
    rise_q.delete(); wait_q.delete(); base_ack = ack_cnt;
    exp_q.push_back(9'h16D);
    push(1'b1, 8'h6D, 1);
    check("ack_pulse", 32'(ack), 32'd1);
    @(negedge clk);
    check("ack_single", 32'(ack), 32'd0);
    wait_idle("t1_idle", 2000);
    t_idle = cyc;
    check("t1_pulses",   32'(rise_q.size()), 32'd2);
    check("t1_setup_lat", 32'(rise_q[0] - ack_cyc), 32'd2);
    check("t1_spacing",  32'(rise_q[1] - rise_q[0]), 32'd15);
    check("t1_settle",   32'(t_idle - last_fall), 32'd644);
    check("t1_wait",     32'(wait_q[0]), 32'd636);
    check("t1_acks",     32'(ack_cnt - base_ack), 32'd1);

    // 2: strobe held 17 cycles pushes once
    base_pulse = n_pulse; base_ack = ack_cnt; max_level = 0;
    exp_q.push_back(9'h0CB);
    push(1'b0, 8'hCB, 17);
    wait_idle("t2_idle", 2000);
    check("t2_acks",   32'(ack_cnt - base_ack), 32'd1);
    check("t2_peak",   32'(max_level), 32'd1);
    check("t2_pulses", 32'(n_pulse - base_pulse), 32'd2);

    // 3: overflow while the engine sits in WAIT
    base_pulse = n_pulse; max_level = 0;
    exp_q.push_back(9'h120);
    push(1'b1, 8'h20, 1);
    n_to = 0;
    while (st != 3'd5 && n_to < 100) begin @(negedge clk); n_to++; end
    check("t3_reach_wait", 32'(st), 32'd5);
    base_ack = ack_cnt;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_q.push_back({1'b1, 8'h30 + 8'(i)});
      push(1'b1, 8'h30 + 8'(i), 1);
    end
    repeat (2) @(negedge clk);
    #1;
    check("t3_acks",  32'(ack_cnt - base_ack), 32'd16);
    check("t3_level", 32'(level), 32'd16);
    check("t3_peak",  32'(max_level), 32'd16);
    check("t3_ovf",   32'(ovf), 32'd1);
    wait_idle("t3_idle", 15000);
    check("t3_pulses", 32'(n_pulse - base_pulse), 32'd34);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // 4: clear-display settle vs normal command settle
    wait_q.delete();
    exp_q.push_back(9'h001); exp_q.push_back(9'h141); exp_q.push_back(9'h080);
    push(1'b0, 8'h01, 1);
    push(1'b1, 8'h41, 1);
    push(1'b0, 8'h80, 1);
    wait_idle("t4_idle", 25000);
    check("t4_waits",  32'(wait_q.size()), 32'd3);
    check("t4_clr",    32'(wait_q[0]), 32'd19200);
    check("t4_data",   32'(wait_q[1]), 32'd636);
    check("t4_cmd80",  32'(wait_q[2]), 32'd636);

    // 5: 8-bit bus, single pulse carrying the whole byte
    cnt_sh = 0; cnt_e8 = 0; rises8 = 0; e8_prev = 1'b0;
    @(negedge clk);
    rs_in = 1'b0; data_in = 8'hCB; stb8 = 1'b1;
    @(negedge clk);
    stb8 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (st8 >= 3'd1 && st8 <= 3'd3 && ldata8 == 8'hCB) cnt_sh++;
      if (le8) cnt_e8++;
      if (le8 && !e8_prev) rises8++;
      e8_prev = le8;
      @(negedge clk);
    end
    check("t5_data_win", 32'(cnt_sh), 32'd8);
    check("t5_e_high",   32'(cnt_e8), 32'd6);
    n_to = 0;
    while (busy8 && n_to < 1000) begin @(negedge clk); n_to++; end
    check("t5_idle",   32'(busy8), 32'd0);
    check("t5_pulses", 32'(rises8), 32'd1);
    check("t5_level",  32'(level8), 32'd0);

    // 6: reset in the middle of an E pulse
    exp_q.push_back(9'h155);
    push(1'b1, 8'h55, 1);
    n_to = 0;
    while (!le && n_to < 20) begin @(negedge clk); n_to++; end
    check("t6_in_pulse", 32'(le), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_e_async", 32'(le),    32'd0);
    check("t6_level",   32'(level), 32'd0);
    check("t6_busy",    32'(busy),  32'd0);
    check("t6_ovf",     32'(ovf),   32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base_pulse = n_pulse; base_ack = ack_cnt;
    exp_q.push_back(9'h148);
    push(1'b1, 8'h48, 1);
    wait_idle("t6_idle", 2000);
    check("t6_acks",    32'(ack_cnt - base_ack), 32'd1);
    check("t6_pulses",  32'(n_pulse - base_pulse), 32'd2);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
